// File: rtl/serv_mem_arbiter_if.sv
// Bus bundle between serv_top (ibus/dbus), the arbiter and the shared
// Wishbone-classic memory port. The arbiter takes the slave view.
interface serv_mem_arbiter_if;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;

    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;

    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;

    logic        o_timeout;
    logic        o_owner;

    modport slave (
        input  i_ibus_adr, i_ibus_cyc,
        output o_ibus_rdt, o_ibus_ack,
        input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        output o_dbus_rdt, o_dbus_ack,
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        input  i_wb_rdt, i_wb_ack,
        output o_timeout, o_owner
    );

    modport master (
        output i_ibus_adr, i_ibus_cyc,
        input  o_ibus_rdt, o_ibus_ack,
        output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        input  o_dbus_rdt, o_dbus_ack,
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        output i_wb_rdt, i_wb_ack,
        input  o_timeout, o_owner
    );
endinterface

// File: rtl/serv_mem_arbiter.sv
// Shares one Wishbone-classic port between SERV ibus and dbus.
// dbus has fixed priority; after each transfer the arbiter waits in RELEASE
// until the served master drops cyc, so a lingering cyc is never re-served.
// Optional watchdog completes a stalled transfer with ERR_DATA.
module serv_mem_arbiter #(
    parameter bit          WITH_TIMEOUT = 1'b1,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    serv_mem_arbiter_if.slave  bus
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    state_t         state;
    logic [31:0]    wb_adr;
    logic [31:0]    wb_dat;
    logic [3:0]     wb_sel;
    logic           wb_we;
    logic           wb_cyc;
    logic           owner;
    logic [WDW-1:0] wdog;

    logic           granted;
    logic           expire;
    logic           done;
    logic           owner_cyc;
    logic [31:0]    rsp_dat;

    assign granted   = (state == GRANT_I) || (state == GRANT_D);
    // A real ack in the last watchdog cycle wins over the abort.
    assign expire    = WITH_TIMEOUT && granted && !bus.i_wb_ack &&
                       (wdog == WDW'(TIMEOUT - 1));
    assign done      = granted && (bus.i_wb_ack || expire);
    assign rsp_dat   = bus.i_wb_ack ? bus.i_wb_rdt : ERR_DATA;
    assign owner_cyc = owner ? bus.i_dbus_cyc : bus.i_ibus_cyc;

    // Master acks are combinational from i_wb_ack; gated by reset so a
    // memory ack during reset never reaches a master.
    assign bus.o_ibus_ack = !i_rst && done && (state == GRANT_I);
    assign bus.o_dbus_ack = !i_rst && done && (state == GRANT_D);
    assign bus.o_ibus_rdt = bus.o_ibus_ack ? rsp_dat : 32'h0;
    assign bus.o_dbus_rdt = bus.o_dbus_ack ? rsp_dat : 32'h0;
    assign bus.o_timeout  = !i_rst && expire;

    assign bus.o_wb_adr = wb_adr;
    assign bus.o_wb_dat = wb_dat;
    assign bus.o_wb_sel = wb_sel;
    assign bus.o_wb_we  = wb_we;
    assign bus.o_wb_cyc = wb_cyc;
    assign bus.o_owner  = owner;

    // Grant FSM: latches the winner's request and owns all registered wb outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            wb_adr <= 32'h0;
            wb_dat <= 32'h0;
            wb_sel <= 4'h0;
            wb_we  <= 1'b0;
            wb_cyc <= 1'b0;
            owner  <= 1'b0;
            wdog   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_dbus_cyc) begin
                        state  <= GRANT_D;
                        wb_adr <= bus.i_dbus_adr;
                        wb_dat <= bus.i_dbus_dat;
                        wb_sel <= bus.i_dbus_sel;
                        wb_we  <= bus.i_dbus_we;
                        wb_cyc <= 1'b1;
                        owner  <= 1'b1;
                        wdog   <= '0;
                    end else if (bus.i_ibus_cyc) begin
                        state  <= GRANT_I;
                        wb_adr <= bus.i_ibus_adr;
                        wb_dat <= 32'h0;
                        wb_sel <= 4'hF;
                        wb_we  <= 1'b0;
                        wb_cyc <= 1'b1;
                        owner  <= 1'b0;
                        wdog   <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    // Master dropping cyc here is ignored; the transfer runs to completion.
                    if (done) begin
                        state  <= RELEASE;
                        wb_cyc <= 1'b0;
                    end else if (WITH_TIMEOUT) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!owner_cyc)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serv_mem_arbiter.sv
// Directed bench: dut0 with an 8-cycle watchdog, dut1 with the watchdog off.
module tb_serv_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serv_mem_arbiter_if a ();
    serv_mem_arbiter_if b ();

    serv_mem_arbiter #(.WITH_TIMEOUT(1'b1), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(a)
    );
    serv_mem_arbiter #(.WITH_TIMEOUT(1'b0), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cyc"},   32'(a.o_wb_cyc), 32'h0);
        chk({tag, "_we"},    32'(a.o_wb_we), 32'h0);
        chk({tag, "_sel"},   32'(a.o_wb_sel), 32'h0);
        chk({tag, "_adr"},   a.o_wb_adr, 32'h0);
        chk({tag, "_dat"},   a.o_wb_dat, 32'h0);
        chk({tag, "_iack"},  32'(a.o_ibus_ack), 32'h0);
        chk({tag, "_dack"},  32'(a.o_dbus_ack), 32'h0);
        chk({tag, "_to"},    32'(a.o_timeout), 32'h0);
        chk({tag, "_owner"}, 32'(a.o_owner), 32'h0);
    endtask

    initial begin
        a.i_ibus_adr = '0; a.i_ibus_cyc = 0;
        a.i_dbus_adr = '0; a.i_dbus_dat = '0; a.i_dbus_sel = '0; a.i_dbus_we = 0; a.i_dbus_cyc = 0;
        a.i_wb_rdt = '0; a.i_wb_ack = 0;
        b.i_ibus_adr = '0; b.i_ibus_cyc = 0;
        b.i_dbus_adr = '0; b.i_dbus_dat = '0; b.i_dbus_sel = '0; b.i_dbus_we = 0; b.i_dbus_cyc = 0;
        b.i_wb_rdt = '0; b.i_wb_ack = 0;

        // Reset state
        cyc(2);
        chk_reset_outs("rst");
        chk("rst_b_cyc", 32'(b.o_wb_cyc), 32'h0);
        rst = 0;

        // Fetch: cyc rises one edge after request, ack two cycles later
        a.i_ibus_adr = 32'h100; a.i_ibus_cyc = 1;
        #1;
        chk("f_no_comb_cyc", 32'(a.o_wb_cyc), 32'h0);
        cyc(1);
        chk("f_cyc", 32'(a.o_wb_cyc), 32'h1);
        chk("f_adr", a.o_wb_adr, 32'h100);
        chk("f_sel", 32'(a.o_wb_sel), 32'hF);
        chk("f_we", 32'(a.o_wb_we), 32'h0);
        chk("f_owner", 32'(a.o_owner), 32'h0);
        cyc(1);
        chk("f_no_early_ack", 32'(a.o_ibus_ack), 32'h0);
        cyc(1);
        a.i_wb_ack = 1; a.i_wb_rdt = 32'h00500093;
        #1;
        chk("f_iack", 32'(a.o_ibus_ack), 32'h1);
        chk("f_irdt", a.o_ibus_rdt, 32'h00500093);
        chk("f_dack", 32'(a.o_dbus_ack), 32'h0);
        chk("f_drdt", a.o_dbus_rdt, 32'h0);
        chk("f_to", 32'(a.o_timeout), 32'h0);
        cyc(1);
        chk("f_cyc_drop", 32'(a.o_wb_cyc), 32'h0);
        chk("f_ack_in_release", 32'(a.o_ibus_ack), 32'h0);
        chk("f_rdt_in_release", a.o_ibus_rdt, 32'h0);
        a.i_wb_ack = 0; a.i_ibus_cyc = 0;
        cyc(1);

        // Collision: dbus store wins, ibus follows 3 edges after dbus ack
        a.i_ibus_adr = 32'h200; a.i_ibus_cyc = 1;
        a.i_dbus_adr = 32'h2000; a.i_dbus_dat = 32'hCAFEF00D; a.i_dbus_sel = 4'b0011;
        a.i_dbus_we = 1; a.i_dbus_cyc = 1;
        cyc(1);
        chk("c_cyc", 32'(a.o_wb_cyc), 32'h1);
        chk("c_owner", 32'(a.o_owner), 32'h1);
        chk("c_we", 32'(a.o_wb_we), 32'h1);
        chk("c_sel", 32'(a.o_wb_sel), 32'h3);
        chk("c_adr", a.o_wb_adr, 32'h2000);
        chk("c_dat", a.o_wb_dat, 32'hCAFEF00D);
        a.i_wb_ack = 1; a.i_wb_rdt = 32'h12345678;
        #1;
        chk("c_dack", 32'(a.o_dbus_ack), 32'h1);
        chk("c_drdt", a.o_dbus_rdt, 32'h12345678);
        chk("c_iack", 32'(a.o_ibus_ack), 32'h0);
        chk("c_irdt", a.o_ibus_rdt, 32'h0);
        cyc(1);
        a.i_wb_ack = 0; a.i_dbus_cyc = 0; a.i_dbus_we = 0;
        chk("c_e1_cyc", 32'(a.o_wb_cyc), 32'h0);
        cyc(1);
        chk("c_e2_cyc", 32'(a.o_wb_cyc), 32'h0);
        cyc(1);
        chk("c_e3_cyc", 32'(a.o_wb_cyc), 32'h1);
        chk("c_e3_owner", 32'(a.o_owner), 32'h0);
        chk("c_e3_adr", a.o_wb_adr, 32'h200);
        chk("c_e3_we", 32'(a.o_wb_we), 32'h0);
        chk("c_e3_sel", 32'(a.o_wb_sel), 32'hF);
        a.i_wb_ack = 1; a.i_wb_rdt = 32'h00000013;
        #1;
        chk("c_i_ack", 32'(a.o_ibus_ack), 32'h1);
        cyc(1);
        a.i_wb_ack = 0; a.i_ibus_cyc = 0;
        cyc(1);

        // Lingering dbus cyc after ack: no second cycle until it drops
        a.i_dbus_adr = 32'h3000; a.i_dbus_sel = 4'hF; a.i_dbus_we = 0; a.i_dbus_cyc = 1;
        a.i_ibus_adr = 32'h400; a.i_ibus_cyc = 1;
        cyc(1);
        chk("l_owner", 32'(a.o_owner), 32'h1);
        a.i_wb_ack = 1; a.i_wb_rdt = 32'h0000BEEF;
        #1;
        chk("l_dack", 32'(a.o_dbus_ack), 32'h1);
        cyc(1);
        a.i_wb_ack = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("l_hold_cyc", 32'(a.o_wb_cyc), 32'h0);
        end
        a.i_dbus_cyc = 0;
        cyc(1);
        chk("l_idle_cyc", 32'(a.o_wb_cyc), 32'h0);
        cyc(1);
        chk("l_grant_i_cyc", 32'(a.o_wb_cyc), 32'h1);
        chk("l_grant_i_owner", 32'(a.o_owner), 32'h0);
        chk("l_grant_i_adr", a.o_wb_adr, 32'h400);
        a.i_wb_ack = 1;
        #1;
        chk("l_iack", 32'(a.o_ibus_ack), 32'h1);
        cyc(1);
        a.i_wb_ack = 0; a.i_ibus_cyc = 0;
        cyc(1);

        // Timeout: no ack, abort in the 8th granted cycle
        a.i_ibus_adr = 32'h500; a.i_ibus_cyc = 1;
        cyc(1);
        chk("t_cyc", 32'(a.o_wb_cyc), 32'h1);
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            chk("t_no_early_to", 32'(a.o_timeout), 32'h0);
            chk("t_no_early_ack", 32'(a.o_ibus_ack), 32'h0);
        end
        cyc(1);
        chk("t_to", 32'(a.o_timeout), 32'h1);
        chk("t_iack", 32'(a.o_ibus_ack), 32'h1);
        chk("t_irdt", a.o_ibus_rdt, 32'hDEADBEEF);
        chk("t_dack", 32'(a.o_dbus_ack), 32'h0);
        cyc(1);
        chk("t_cyc_drop", 32'(a.o_wb_cyc), 32'h0);
        chk("t_to_pulse", 32'(a.o_timeout), 32'h0);
        a.i_ibus_cyc = 0;
        cyc(1);

        // Ack in the last watchdog cycle beats the abort
        a.i_ibus_adr = 32'h600; a.i_ibus_cyc = 1;
        cyc(1);
        cyc(7);
        a.i_wb_ack = 1; a.i_wb_rdt = 32'hA5A5A5A5;
        #1;
        chk("t8_iack", 32'(a.o_ibus_ack), 32'h1);
        chk("t8_irdt", a.o_ibus_rdt, 32'hA5A5A5A5);
        chk("t8_to", 32'(a.o_timeout), 32'h0);
        cyc(1);
        a.i_wb_ack = 0; a.i_ibus_cyc = 0;
        chk("t8_cyc_drop", 32'(a.o_wb_cyc), 32'h0);
        cyc(1);

        // Reset mid-transfer with a concurrent memory ack
        a.i_dbus_adr = 32'h6000; a.i_dbus_dat = 32'h11; a.i_dbus_sel = 4'hF;
        a.i_dbus_we = 1; a.i_dbus_cyc = 1;
        cyc(1);
        chk("r_cyc", 32'(a.o_wb_cyc), 32'h1);
        rst = 1; a.i_wb_ack = 1; a.i_wb_rdt = 32'h77777777;
        #1;
        chk("r_no_dack", 32'(a.o_dbus_ack), 32'h0);
        chk("r_no_drdt", a.o_dbus_rdt, 32'h0);
        cyc(1);
        chk_reset_outs("r");
        rst = 0; a.i_wb_ack = 0; a.i_dbus_cyc = 0; a.i_dbus_we = 0;
        cyc(1);

        // Watchdog disabled: ack withheld 1000 cycles, then a late ack
        b.i_ibus_adr = 32'h700; b.i_ibus_cyc = 1;
        cyc(1);
        chk("n_cyc", 32'(b.o_wb_cyc), 32'h1);
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            chk("n_hold", {30'h0, b.o_wb_cyc, b.o_ibus_ack}, 32'h2);
        end
        chk("n_no_to", 32'(b.o_timeout), 32'h0);
        b.i_wb_ack = 1; b.i_wb_rdt = 32'h0BADF00D;
        #1;
        chk("n_iack", 32'(b.o_ibus_ack), 32'h1);
        chk("n_irdt", b.o_ibus_rdt, 32'h0BADF00D);
        chk("n_to", 32'(b.o_timeout), 32'h0);
        cyc(1);
        b.i_wb_ack = 0; b.i_ibus_cyc = 0;
        chk("n_cyc_drop", 32'(b.o_wb_cyc), 32'h0);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
